pj_detector_jogada: RTL and testbench
=====================================

Name: pj_detector_jogada

Overview:
- Upstream input stage of the quiz game control unit.
- Synchronizes and debounces the raw answer buttons.
- Turns a single clean press into a one-cycle `jogada` pulse, with the one-hot button code captured alongside it.
- Only arms while the control unit enables it (ESPERA_JOGADA). Requires full release between answers. Rejects multi-button presses.

Parameters:
- N_BOTOES, 4, number of answer buttons (width of `botoes`/`codigo`).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a level change (1 ms at 50 MHz). Must be ≥ 2.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- habilita  in  1  high while the control unit waits for an answer.
- botoes  in  N_BOTOES  raw asynchronous push-buttons, active-high.
- jogada  out  1  one-cycle pulse: one valid answer captured.
- codigo  out  N_BOTOES  one-hot code of the captured button; held until the next capture.
- multiplo  out  1  one-cycle pulse: press rejected (more than one button down).
- db_estado  out  4  current FSM state, for debug.

Behaviour:
- Reset (synchronous, reset=1 at a rising edge) clears:
  - both synchronizer stages;
  - the debounced vector `deb`;
  - all debounce counters;
  - `codigo` = 0;
  - FSM = REPOUSO.
  - Result: `jogada` = 0, `multiplo` = 0, `db_estado` = 0. Reset applied mid-press forces the same state.
- Synchronizer: 2 flip-flops per bit (`s1` <= `botoes`, `s2` <= `s1`).
- Debounce, per bit i, with counter width $clog2(DEBOUNCE_CYCLES+1):
  - If `s2[i]` == `deb[i]`: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: `deb[i]` <= `s2[i]` and counter <= 0.
  - Else: counter++.
  - A glitch shorter than DEBOUNCE_CYCLES is never seen on `deb`. The same rule applies to press and release.
- FSM, Moore outputs (`db_estado` value in brackets):
  - REPOUSO [0]: if `habilita` -> ESPERA_SOLTAR.
  - ESPERA_SOLTAR [1]:
    - `habilita`=0 -> REPOUSO.
    - else `deb`==0 -> ARMADO.
    - Covers a button still held from the previous answer.
  - ARMADO [2]:
    - `habilita`=0 -> REPOUSO.
    - else `deb` has exactly one bit set -> CAPTURA, with `codigo` <= `deb` at the same edge.
    - else `deb` has ≥2 bits set -> REJEITA.
    - else stay.
  - CAPTURA [3]: `jogada`=1 -> ESPERA_SOLTAR (unconditional; the pulse always completes even if `habilita` falls).
  - REJEITA [4]: `multiplo`=1 -> ESPERA_SOLTAR. `codigo` is unchanged.
  - Any other encoding -> REPOUSO.
- `jogada` and `multiplo` are decoded from the state: each is exactly one cycle wide and they are never high together.
- `codigo` is registered and stable in the `jogada` cycle. It is held through later states, including REPOUSO.
- Latency: `botoes[i]` rises before edge E0 and stays stable. Then:
  - `deb[i]` rises at edge E0+DEBOUNCE_CYCLES+1;
  - ARMADO -> CAPTURA at edge E0+DEBOUNCE_CYCLES+2;
  - `jogada` is high for the following cycle.
- Two buttons whose `deb` bits rise on different edges: the first one to appear alone in ARMADO wins. The later bit is ignored until all buttons are released.
- A button held continuously across answers never produces a second `jogada`; it must be released (debounced) first.

Test Plan (DEBOUNCE_CYCLES=4, N_BOTOES=4):
- Reset, `habilita`=1, `botoes`=0000, then `botoes`=0100 clean from edge E0 -> `jogada`=1 only in the cycle after edge E0+6; `codigo`=0100; `db_estado` sequence 0,1,2,3,1.
- Pulse `botoes`=0010 for 3 cycles in ARMADO -> no `jogada`, `deb` stays 0000, state stays 2.
- `botoes`=0011 applied on the same edge -> `multiplo` one cycle, `jogada` never, `codigo` keeps its previous value, state 4 -> 1.
- Hold `botoes`=0001 through a capture, drop `habilita` and raise it again -> state stays 1 while held. After release plus 6 cycles -> 2. Re-press -> second `jogada`, `codigo`=0001.
- `habilita`=0 with `botoes`=1000 pressed -> state 0, no `jogada`, no `multiplo`. Raising `habilita` while still held -> waits in state 1.
- Assert `reset` for one cycle while `deb`=0100 and in state 1 -> next cycle `db_estado`=0, `codigo`=0000, outputs 0, debounce counters restart.

Source files
------------

// File: rtl/pj_detector_jogada.sv
// Answer-button input stage of the quiz control unit: 2-FF synchronizer, per-bit debounce,
// and a Moore FSM that turns one clean single-button press into a jogada pulse with its code.
module pj_detector_jogada #(
    parameter int N_BOTOES        = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                habilita,
    input  logic [N_BOTOES-1:0] botoes,
    output logic                jogada,
    output logic [N_BOTOES-1:0] codigo,
    output logic                multiplo,
    output logic [3:0]          db_estado
);

    localparam int            CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] ULTIMO = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        REPOUSO       = 3'd0,
        ESPERA_SOLTAR = 3'd1,
        ARMADO        = 3'd2,
        CAPTURA       = 3'd3,
        REJEITA       = 3'd4
    } estado_t;

    estado_t             estado;
    estado_t             proximo;
    logic [N_BOTOES-1:0] s1;
    logic [N_BOTOES-1:0] s2;
    logic [N_BOTOES-1:0] deb;
    logic [CW-1:0]       contador [N_BOTOES];
    logic                um_botao;
    logic                varios;
    logic                captura_en;

    // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= botoes;
            s2 <= s1;
        end
    end

    // A level change on s2 must persist for DEBOUNCE_CYCLES consecutive edges before deb follows it.
    for (genvar i = 0; i < N_BOTOES; i++) begin : g_debounce
        // NOTE: the counter array is a handful of flops, not RAM, so it is cleared with everything else.
        always_ff @(posedge clock) begin
            if (reset) begin
                deb[i]      <= 1'b0;
                contador[i] <= '0;
            end else if (s2[i] == deb[i]) begin
                contador[i] <= '0;
            end else if (contador[i] == ULTIMO) begin
                deb[i]      <= s2[i];
                contador[i] <= '0;
            end else begin
                contador[i] <= contador[i] + CW'(1);
            end
        end
    end

    // x & (x-1) clears the lowest set bit: zero means at most one bit was set.
    always_comb begin
        varios   = (deb & (deb - N_BOTOES'(1))) != '0;
        um_botao = (deb != '0) && !varios;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= REPOUSO;
        end else begin
            estado <= proximo;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        proximo    = estado;
        captura_en = 1'b0;
        case (estado)
            REPOUSO: begin
                if (habilita) begin
                    proximo = ESPERA_SOLTAR;
                end
            end
            ESPERA_SOLTAR: begin
                if (!habilita) begin
                    proximo = REPOUSO;
                end else if (deb == '0) begin
                    proximo = ARMADO;
                end
            end
            ARMADO: begin
                if (!habilita) begin
                    proximo = REPOUSO;
                end else if (um_botao) begin
                    proximo    = CAPTURA;
                    captura_en = 1'b1;
                end else if (varios) begin
                    proximo = REJEITA;
                end
            end
            CAPTURA: proximo = ESPERA_SOLTAR;
            REJEITA: proximo = ESPERA_SOLTAR;
            default: proximo = REPOUSO;
        endcase
    end

    // codigo is loaded on the ARMADO->CAPTURA edge and held until the next capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            codigo <= '0;
        end else if (captura_en) begin
            codigo <= deb;
        end
    end

    always_comb begin
        jogada    = (estado == CAPTURA);
        multiplo  = (estado == REJEITA);
        db_estado = {1'b0, estado};
    end

endmodule

// File: tb/tb_pj_detector_jogada.sv
// Bench for pj_detector_jogada: per-cycle comparison against a behavioural model plus
// directed scenarios with hand-computed latencies (DEBOUNCE_CYCLES=4, N_BOTOES=4).
module tb_pj_detector_jogada;

    localparam int N = 4;
    localparam int D = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         habilita;
    logic [N-1:0] botoes;
    logic         jogada;
    logic         multiplo;
    logic [N-1:0] codigo;
    logic [3:0]   db_estado;

    int n_cmp = 0;
    int n_bad = 0;

    pj_detector_jogada #(.N_BOTOES(N), .DEBOUNCE_CYCLES(D)) dut (
        .clock    (clock),
        .reset    (reset),
        .habilita (habilita),
        .botoes   (botoes),
        .jogada   (jogada),
        .codigo   (codigo),
        .multiplo (multiplo),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_cmp++;
        if (atual !== esperado) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nome, atual, esperado, $time);
        end
    endtask

    // Behavioural model: inputs are delayed two edges, a bit of deb follows after D consecutive
    // disagreeing edges, and the answer flow is tracked as a plain state number.
    logic [N-1:0] m_s1, m_s2, m_deb, m_cod;
    int           m_run [N];
    int           m_st;
    bit           m_valid = 1'b0;

    task automatic model_advance();
        int n_on;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_cod = '0; m_st = 0; m_valid = 1'b1;
            for (int i = 0; i < N; i++) m_run[i] = 0;
        end else if (m_valid) begin
            n_on = $countones(m_deb);
            case (m_st)
                0: if (habilita) m_st = 1;
                1: if (!habilita) m_st = 0; else if (n_on == 0) m_st = 2;
                2: if (!habilita) m_st = 0;
                   else if (n_on == 1) begin m_st = 3; m_cod = m_deb; end
                   else if (n_on > 1) m_st = 4;
                default: m_st = 1;
            endcase
            for (int i = 0; i < N; i++) begin
                if (m_s2[i] != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_deb[i] = m_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = botoes;
        end
    endtask

    // Inputs change just after a rising edge, so at the falling edge they already hold
    // what the next rising edge will sample.
    initial begin
        forever begin
            @(negedge clock);
            if (m_valid) begin
                check("model_jogada",    jogada,    m_st == 3);
                check("model_multiplo",  multiplo,  m_st == 4);
                check("model_db_estado", db_estado, m_st);
                check("model_codigo",    codigo,    m_cod);
            end
            model_advance();
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_state(input int alvo, input int limite, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (db_estado != alvo && n < limite);
        check("wait_state_reached", db_estado, alvo);
    endtask

    initial begin
        int n;
        reset = 1'b1; habilita = 1'b0; botoes = '0;
        step(); step();
        check("reset_estado", db_estado, 0);
        check("reset_jogada", jogada, 0);
        check("reset_multiplo", multiplo, 0);
        check("reset_codigo", codigo, 0);
        reset = 1'b0; habilita = 1'b1;

        // Clean single press: capture D+2 edges after the first edge that sees it.
        step(); check("t1_espera_soltar", db_estado, 1);
        step(); check("t1_armado", db_estado, 2);
        botoes = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            step();
            check("t1_ainda_armado", db_estado, 2);
            check("t1_sem_jogada", jogada, 0);
        end
        step();
        check("t1_captura", db_estado, 3);
        check("t1_jogada", jogada, 1);
        check("t1_codigo", codigo, 4'b0100);
        step();
        check("t1_volta_espera", db_estado, 1);
        check("t1_pulso_unico", jogada, 0);
        botoes = '0;
        wait_state(2, 20, n);
        check("t1_latencia_soltar", n, 7);

        // Glitch of 3 cycles is filtered.
        botoes = 4'b0010;
        for (int k = 0; k < 3; k++) begin step(); check("t2_glitch_estado", db_estado, 2); end
        botoes = '0;
        for (int k = 0; k < 8; k++) begin
            step();
            check("t2_glitch_estado", db_estado, 2);
            check("t2_glitch_jogada", jogada, 0);
        end

        // Two buttons on the same edge are rejected.
        botoes = 4'b0011;
        wait_state(4, 20, n);
        check("t3_latencia_rejeita", n, 7);
        check("t3_multiplo", multiplo, 1);
        check("t3_sem_jogada", jogada, 0);
        check("t3_codigo_mantido", codigo, 4'b0100);
        step();
        check("t3_volta_espera", db_estado, 1);
        check("t3_multiplo_fim", multiplo, 0);
        botoes = '0;
        wait_state(2, 20, n);
        check("t3_latencia_soltar", n, 7);

        // Held button across a habilita drop never produces a second capture.
        botoes = 4'b0001;
        wait_state(3, 20, n);
        check("t4_latencia_captura", n, 7);
        check("t4_codigo", codigo, 4'b0001);
        step(); check("t4_espera", db_estado, 1);
        habilita = 1'b0;
        step(); check("t4_repouso", db_estado, 0);
        habilita = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check("t4_segura", db_estado, 1);
            check("t4_sem_jogada", jogada, 0);
        end
        botoes = '0;
        wait_state(2, 20, n);
        check("t4_latencia_soltar", n, 7);
        botoes = 4'b0001;
        wait_state(3, 20, n);
        check("t4_segunda_latencia", n, 7);
        check("t4_segunda_jogada", jogada, 1);
        check("t4_segundo_codigo", codigo, 4'b0001);
        step();
        botoes = '0;
        wait_state(2, 20, n);

        // Press while disabled: idle, then wait for release once enabled.
        habilita = 1'b0;
        step(); check("t5_repouso", db_estado, 0);
        botoes = 4'b1000;
        for (int k = 0; k < 10; k++) begin
            step();
            check("t5_repouso_mantido", db_estado, 0);
            check("t5_sem_jogada", jogada, 0);
            check("t5_sem_multiplo", multiplo, 0);
        end
        habilita = 1'b1;
        for (int k = 0; k < 6; k++) begin step(); check("t5_espera_soltar", db_estado, 1); end
        botoes = '0;
        wait_state(2, 20, n);
        check("t5_latencia_soltar", n, 7);

        // Reset mid-press clears everything and the debounce restarts from scratch.
        botoes = 4'b0100;
        wait_state(3, 20, n);
        step(); check("t6_espera", db_estado, 1);
        reset = 1'b1;
        step();
        check("t6_reset_estado", db_estado, 0);
        check("t6_reset_codigo", codigo, 0);
        check("t6_reset_jogada", jogada, 0);
        check("t6_reset_multiplo", multiplo, 0);
        reset = 1'b0;
        wait_state(3, 20, n);
        check("t6_latencia_reinicio", n, 7);
        check("t6_codigo", codigo, 4'b0100);
        step();
        botoes = '0;
        wait_state(2, 20, n);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected summary");
        $fatal(1, "watchdog timeout");
    end

endmodule
